catch_ball_engine: RTL and testbench
====================================

Name: catch_ball_engine

Overview:
- Game core of the 2-player catch design.
- Consumes the cleaned one-shot button pulses from three debouncers: serve, player A, player B.
- Moves a single lit "ball" across an LED row, judges catches and misses, keeps both scores and declares the winner.
- Outputs drive the LED row and the score displays directly.

Parameters:
LEDS, 8, number of LEDs in the ball row; position 0 = player A end, LEDS-1 = player B end
STEP_TICKS, 25000000, clock cycles per ball step (0.5 s at 50 MHz)
CNT_W, 25, width of the step counter; must satisfy 2^CNT_W > STEP_TICKS
SCORE_MAX, 9, score that ends the game (max 15)

Ports:
Clock    input   1     system clock
Reset    input   1     asynchronous, active-high reset
Serve    input   1     one-shot, single-cycle: serve or restart
Shot_A   input   1     one-shot, single-cycle: player A catch press
Shot_B   input   1     one-shot, single-cycle: player B catch press
Leds     output  LEDS  ball display
Score_A  output  4     player A score
Score_B  output  4     player B score
Winner   output  2     00 none, 01 A, 10 B
Busy     output  1     1 while the ball is in flight

Behaviour:
Reset and clocking:
- Reset is asynchronous and active-high; clock is Clock.
- All state is registered on posedge Clock.
- Reset values: state IDLE, pos 0, server A, step count 0, Score_A 0, Score_B 0, Winner 00, Busy 0, Leds one-hot bit 0.

Leds mapping:
- IDLE / MOVE_R / MOVE_L: one-hot of pos.
- POINT: all ones.
- GAME_OVER: all ones.

States:
- IDLE: ball parked at the server's end (pos 0 for A, LEDS-1 for B).
  - Serve=1 -> next cycle MOVE_R if server A, MOVE_L if server B.
  - On that transition step count clears and pos is unchanged.
  - Shot_A and Shot_B are ignored in IDLE.
- MOVE_R (toward B): step count increments each cycle.
  - At STEP_TICKS-1 the count wraps to 0 and a step fires.
  - Step with pos<LEDS-1: pos+1.
  - Step with pos==LEDS-1: B missed -> Score_A+1, go to POINT.
  - Shot_B with pos==LEDS-1: catch -> state MOVE_L, step count cleared, pos unchanged.
  - Shot_B with pos<LEDS-1: early press fault -> Score_A+1, go to POINT.
  - Shot_A is ignored in MOVE_R.
- MOVE_L: mirror of MOVE_R with A/B swapped and pos decrementing toward 0.
- POINT: hold for exactly STEP_TICKS cycles, reusing the step counter.
  - Then, if the scorer's score == SCORE_MAX -> GAME_OVER, Winner set.
  - Otherwise -> IDLE with server = the player who lost the point, pos = that player's end.
- GAME_OVER: Serve -> IDLE with both scores 0, Winner 00, server A, pos 0.

Simultaneous events and priorities:
- Shot press and step fire in the same cycle: the press has priority, evaluated against the current pos.
  - Example: ball at pos LEDS-1 and step fires with Shot_B -> catch.
- Serve outside IDLE and GAME_OVER is ignored.
- Shot inputs are ignored in POINT and GAME_OVER.

Other rules:
- Busy=1 in MOVE_R and MOVE_L only.
- Scores saturate at SCORE_MAX; there is no wrap.
- Reset mid-rally returns immediately to reset values; no point is awarded.
- Inputs are assumed already synchronous single-cycle pulses; no additional edge detection is done here.

Test Plan:
- Use LEDS=8, STEP_TICKS=4, SCORE_MAX=3 for all scenarios.
1. Reset, Serve pulse -> Busy=1 next cycle; Leds 0x01 held 4 cycles, then 0x02, 0x04 … 0x80 at 4-cycle intervals.
2. Ball at 0x80, Shot_B on 2nd cycle there -> MOVE_L; Leds 0x80 held 4 more cycles, then 0x40; scores stay 0/0.
3. Ball reaches 0x80, no press -> 4 cycles later Score_A=1, Leds=0xFF for 4 cycles, then IDLE with Leds=0x80 (B serves), Busy=0.
4. Shot_B while Leds=0x08 -> next cycle Score_A=1, Leds=0xFF; Shot_A pulses during MOVE_R have no effect.
5. A wins three points -> Score_A=3, Winner=01, Leds=0xFF and held; Serve -> scores 0/0, Winner 00, Leds 0x01.
6. Reset asserted mid-flight at Leds=0x10 -> outputs return to reset values asynchronously; release and Serve -> normal restart from pos 0.

Source files
------------

// File: rtl/catch_ball_engine.sv
// catch_ball_engine: two-player catch game core.
// Moves one lit ball across an LED row, judges catches, early presses and
// misses, keeps both scores and declares the winner.
module catch_ball_engine #(
  parameter int LEDS       = 8,
  parameter int STEP_TICKS = 25000000,
  parameter int CNT_W      = 25,
  parameter int SCORE_MAX  = 9
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Serve,
  input  logic            Shot_A,
  input  logic            Shot_B,
  output logic [LEDS-1:0] Leds,
  output logic [3:0]      Score_A,
  output logic [3:0]      Score_B,
  output logic [1:0]      Winner,
  output logic            Busy
);

  localparam int                POS_W     = (LEDS > 1) ? $clog2(LEDS) : 1;
  localparam logic [POS_W-1:0]  POS_A     = '0;
  localparam logic [POS_W-1:0]  POS_B     = POS_W'(LEDS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_TICKS - 1);
  localparam logic [3:0]        SCORE_TOP = 4'(SCORE_MAX);
  localparam logic [LEDS-1:0]   LED_ONE   = LEDS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_R,
    S_MOVE_L,
    S_POINT,
    S_GAME_OVER
  } state_t;

  state_t           r_state,    w_next_state;
  logic [POS_W-1:0] r_pos,      w_next_pos;
  logic             r_server_b, w_next_server_b;  // 1: player B serves next
  logic             r_scorer_b, w_next_scorer_b;  // 1: player B won the last point
  logic [CNT_W-1:0] r_cnt,      w_next_cnt;
  logic [3:0]       r_score_a,  w_next_score_a;
  logic [3:0]       r_score_b,  w_next_score_b;
  logic [1:0]       r_winner,   w_next_winner;

  logic             w_step;
  logic [3:0]       w_score_a_inc;
  logic [3:0]       w_score_b_inc;
  logic [3:0]       w_scorer_score;

  assign w_step         = (r_cnt == CNT_LAST);
  assign w_score_a_inc  = (r_score_a >= SCORE_TOP) ? SCORE_TOP : r_score_a + 4'd1;
  assign w_score_b_inc  = (r_score_b >= SCORE_TOP) ? SCORE_TOP : r_score_b + 4'd1;
  assign w_scorer_score = r_scorer_b ? r_score_b : r_score_a;

  // Register every piece of game state; Reset parks the ball at A's end.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_pos      <= POS_A;
      r_server_b <= 1'b0;
      r_scorer_b <= 1'b0;
      r_cnt      <= '0;
      r_score_a  <= '0;
      r_score_b  <= '0;
      r_winner   <= 2'b00;
    end else begin
      r_state    <= w_next_state;
      r_pos      <= w_next_pos;
      r_server_b <= w_next_server_b;
      r_scorer_b <= w_next_scorer_b;
      r_cnt      <= w_next_cnt;
      r_score_a  <= w_next_score_a;
      r_score_b  <= w_next_score_b;
      r_winner   <= w_next_winner;
    end
  end

  // Next-state logic: a shot press beats a step firing in the same cycle.
  // NOTE: every signal gets its hold value first so no path can infer a latch.
  always_comb begin
    w_next_state    = r_state;
    w_next_pos      = r_pos;
    w_next_server_b = r_server_b;
    w_next_scorer_b = r_scorer_b;
    w_next_cnt      = r_cnt;
    w_next_score_a  = r_score_a;
    w_next_score_b  = r_score_b;
    w_next_winner   = r_winner;

    case (r_state)
      S_IDLE: begin
        if (Serve) begin
          w_next_state = r_server_b ? S_MOVE_L : S_MOVE_R;
          w_next_cnt   = '0;
        end
      end

      S_MOVE_R: begin
        if (Shot_B) begin
          if (r_pos == POS_B) begin
            w_next_state = S_MOVE_L;
            w_next_cnt   = '0;
          end else begin
            // Early press by B hands the point to A.
            w_next_score_a  = w_score_a_inc;
            w_next_scorer_b = 1'b0;
            w_next_state    = S_POINT;
            w_next_cnt      = '0;
          end
        end else if (w_step) begin
          w_next_cnt = '0;
          if (r_pos == POS_B) begin
            w_next_score_a  = w_score_a_inc;
            w_next_scorer_b = 1'b0;
            w_next_state    = S_POINT;
          end else begin
            w_next_pos = r_pos + POS_W'(1);
          end
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_MOVE_L: begin
        if (Shot_A) begin
          if (r_pos == POS_A) begin
            w_next_state = S_MOVE_R;
            w_next_cnt   = '0;
          end else begin
            w_next_score_b  = w_score_b_inc;
            w_next_scorer_b = 1'b1;
            w_next_state    = S_POINT;
            w_next_cnt      = '0;
          end
        end else if (w_step) begin
          w_next_cnt = '0;
          if (r_pos == POS_A) begin
            w_next_score_b  = w_score_b_inc;
            w_next_scorer_b = 1'b1;
            w_next_state    = S_POINT;
          end else begin
            w_next_pos = r_pos - POS_W'(1);
          end
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_POINT: begin
        if (w_step) begin
          w_next_cnt = '0;
          if (w_scorer_score == SCORE_TOP) begin
            w_next_state  = S_GAME_OVER;
            w_next_winner = r_scorer_b ? 2'b10 : 2'b01;
          end else begin
            // The player who lost the point serves from their own end.
            w_next_state    = S_IDLE;
            w_next_server_b = ~r_scorer_b;
            w_next_pos      = r_scorer_b ? POS_A : POS_B;
          end
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_GAME_OVER: begin
        if (Serve) begin
          w_next_state    = S_IDLE;
          w_next_score_a  = '0;
          w_next_score_b  = '0;
          w_next_winner   = 2'b00;
          w_next_server_b = 1'b0;
          w_next_pos      = POS_A;
          w_next_cnt      = '0;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Display: one-hot ball while parked or flying, full row during a point or game over.
  always_comb begin
    if (r_state == S_POINT || r_state == S_GAME_OVER) begin
      Leds = '1;
    end else begin
      Leds = LED_ONE << r_pos;
    end
  end

  assign Score_A = r_score_a;
  assign Score_B = r_score_b;
  assign Winner  = r_winner;
  assign Busy    = (r_state == S_MOVE_R) || (r_state == S_MOVE_L);

endmodule

// File: tb/tb_catch_ball_engine.sv
// Testbench for catch_ball_engine: directed game scenarios followed by random
// button traffic, all checked against a rule-level game model via a scoreboard.
module tb_catch_ball_engine;

  localparam int LEDS       = 8;
  localparam int STEP_TICKS = 4;
  localparam int CNT_W      = 3;
  localparam int SCORE_MAX  = 3;

  localparam int PH_IDLE  = 0;
  localparam int PH_FLY   = 1;
  localparam int PH_POINT = 2;
  localparam int PH_OVER  = 3;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic            Serve = 1'b0;
  logic            Shot_A = 1'b0;
  logic            Shot_B = 1'b0;
  logic [LEDS-1:0] Leds;
  logic [3:0]      Score_A;
  logic [3:0]      Score_B;
  logic [1:0]      Winner;
  logic            Busy;

  catch_ball_engine #(
    .LEDS(LEDS), .STEP_TICKS(STEP_TICKS), .CNT_W(CNT_W), .SCORE_MAX(SCORE_MAX)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Serve(Serve), .Shot_A(Shot_A), .Shot_B(Shot_B),
    .Leds(Leds), .Score_A(Score_A), .Score_B(Score_B), .Winner(Winner), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- rule-level game model ----------------
  typedef struct {
    logic [LEDS-1:0] leds;
    logic [3:0]      sa;
    logic [3:0]      sb;
    logic [1:0]      win;
    logic            busy;
  } exp_t;

  exp_t q[$];

  int m_phase, m_pos, m_dir, m_server, m_timer, m_scorer, m_winner;
  int m_score[2];

  function automatic int end_of(input int player);
    return (player == 0) ? 0 : LEDS - 1;
  endfunction

  task automatic model_reset();
    m_phase    = PH_IDLE;
    m_pos      = 0;
    m_dir      = 1;
    m_server   = 0;
    m_timer    = STEP_TICKS;
    m_scorer   = 0;
    m_winner   = 0;
    m_score[0] = 0;
    m_score[1] = 0;
  endtask

  task automatic award(input int p);
    m_score[p] = (m_score[p] + 1 > SCORE_MAX) ? SCORE_MAX : m_score[p] + 1;
    m_scorer   = p;
    m_phase    = PH_POINT;
    m_timer    = STEP_TICKS;
  endtask

  task automatic model_step(input bit serve, input bit a, input bit b);
    int  recv;
    bit  press;
    case (m_phase)
      PH_IDLE: if (serve) begin
        m_phase = PH_FLY;
        m_dir   = (m_server == 0) ? 1 : -1;
        m_timer = STEP_TICKS;
      end
      PH_FLY: begin
        recv  = (m_dir > 0) ? 1 : 0;
        press = recv ? b : a;
        if (press) begin
          if (m_pos == end_of(recv)) begin
            m_dir   = -m_dir;
            m_timer = STEP_TICKS;
          end else begin
            award(1 - recv);
          end
        end else begin
          m_timer--;
          if (m_timer == 0) begin
            if (m_pos == end_of(recv)) award(1 - recv);
            else begin
              m_pos   = m_pos + m_dir;
              m_timer = STEP_TICKS;
            end
          end
        end
      end
      PH_POINT: begin
        m_timer--;
        if (m_timer == 0) begin
          if (m_score[m_scorer] == SCORE_MAX) begin
            m_phase  = PH_OVER;
            m_winner = m_scorer + 1;
          end else begin
            m_phase  = PH_IDLE;
            m_server = 1 - m_scorer;
            m_pos    = end_of(m_server);
          end
        end
      end
      default: if (serve) model_reset();
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.leds = (m_phase == PH_POINT || m_phase == PH_OVER) ? '1 : LEDS'(1 << m_pos);
    e.sa   = 4'(m_score[0]);
    e.sb   = 4'(m_score[1]);
    e.win  = 2'(m_winner);
    e.busy = (m_phase == PH_FLY);
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input bit rst, input bit serve, input bit a, input bit b);
    exp_t e;
    @(negedge Clock);
    Reset  = rst;
    Serve  = serve;
    Shot_A = a;
    Shot_B = b;
    #1;
    if (rst) begin
      model_reset();
      e = model_out();
      check("async_rst_leds",  Leds,    e.leds);
      check("async_rst_sa",    Score_A, e.sa);
      check("async_rst_sb",    Score_B, e.sb);
      check("async_rst_win",   Winner,  e.win);
      check("async_rst_busy",  Busy,    e.busy);
    end else begin
      model_step(serve, a, b);
    end
    q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_until_pos(input int p, input int max_cycles);
    int n = 0;
    while (!(m_phase == PH_FLY && m_pos == p) && n < max_cycles) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("reach_pos", (m_phase == PH_FLY && m_pos == p), 1);
  endtask

  task automatic run_until_phase(input int ph, input int max_cycles);
    int n = 0;
    while (m_phase != ph && n < max_cycles) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("reach_phase", m_phase, ph);
  endtask

  task automatic wait_step_fire();
    for (int i = 0; i < STEP_TICKS && m_timer != 1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("leds",    Leds,    e.leds);
        check("score_a", Score_A, e.sa);
        check("score_b", Score_B, e.sb);
        check("winner",  Winner,  e.win);
        check("busy",    Busy,    e.busy);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Serve from A and let the ball cross to B's end.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_until_pos(LEDS - 1, 100);

    // B catches on the second cycle at the end; A catches on the step-fire cycle.
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(6);
    run_until_pos(0, 100);
    wait_step_fire();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // A presses while the ball flies right (ignored); B misses.
    run_until_pos(2, 100);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_until_phase(PH_IDLE, 200);

    // B serves; stray serve ignored; A catches; early B press awards A.
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_until_pos(LEDS - 2, 100);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_until_pos(0, 100);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_until_pos(3, 100);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    run_until_phase(PH_IDLE, 200);

    // A takes the third point and the game; shots and the hold are checked.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_until_pos(0, 100);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_until_phase(PH_OVER, 300);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, i[0], i[1]);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Reset mid-flight, then a normal restart from A's end.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_until_pos(4, 100);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_until_pos(2, 100);

    // Random button traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 599) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 15) == 0));
    end

    @(posedge Clock);
    #3;
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
